// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/halt controller:
// FSM state encoding, register-specifier width and the IF/ID NOP pattern.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int REG_W = 5;

  // Instruction word loaded into IF/ID on a flush; all-zero decodes as NOP.
  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencer: load-use stall, taken-branch flush, HALT drain and
// debug resume, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             dbg_resume,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_run,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import pipe_ctrl_pkg::*;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t         state_r, state_nxt;
  logic [DW-1:0]  drain_r, drain_nxt;
  logic           lu_s;
  logic           stall_inc_s;
  logic           flush_inc_s;

  assign lu_s = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Next-state and zero-latency latch controls; reset forces the safe pattern.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    pipe_run     = 1'b0;
    halted       = 1'b0;
    state_nxt    = state_r;
    drain_nxt    = drain_r;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;
    if (reset) begin
      case (state_r)
        ST_RUN: begin
          pipe_run = 1'b1;
          // The ID instruction is on the wrong path when a branch resolves taken.
          if (ex_branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            flush_inc_s = 1'b1;
          end else if (lu_s) begin
            stall_inc_s = 1'b1;
          end else if (id_halt) begin
            drain_nxt = DRAIN_LOAD;
            state_nxt = ST_DRAIN;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
          end
        end
        ST_DRAIN: begin
          pipe_run = 1'b1;
          if (drain_r == '0) begin
            state_nxt = ST_HALTED;
          end else begin
            drain_nxt = drain_r - {{(DW-1){1'b0}}, 1'b1};
          end
        end
        ST_HALTED: begin
          id_ex_bubble = 1'b0;
          halted       = 1'b1;
          // Resume discards the HALT still sitting in IF/ID.
          if (dbg_resume) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            pipe_run    = 1'b1;
            state_nxt   = ST_RUN;
          end else begin
            state_nxt = ST_HALTED;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          drain_nxt = '0;
        end
      endcase
    end else begin
      state_nxt = ST_RUN;
      drain_nxt = '0;
    end
  end

  // FSM state and drain down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      drain_r <= '0;
    end else begin
      state_r <= state_nxt;
      drain_r <= drain_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (stall_inc_s),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (flush_inc_s),
    .q     (flush_cnt)
  );

endmodule
